// File: rtl/cu_pkg.sv
// Shared constants and types for the multi-cycle control unit:
// opcodes, ALU codes, operand selects, FSM state and instruction class.
package cu_pkg;

    // Base opcodes (instruction[6:0])
    localparam logic [6:0] OpcRtype  = 7'b0110011;
    localparam logic [6:0] OpcItype  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    // Only word-sized memory accesses are supported
    localparam logic [2:0] F3Word = 3'b010;

    // ALU operation codes, zero-extended to the ALU port width
    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSrl = 3'd1;
    localparam logic [2:0] AluOr  = 3'd2;
    localparam logic [2:0] AluAnd = 3'd3;
    localparam logic [2:0] AluSub = 3'd4;
    localparam logic [2:0] AluXor = 3'd5;
    localparam logic [2:0] AluSlt = 3'd6;
    localparam logic [2:0] AluSll = 3'd7;

    // Operand-1 selects
    localparam logic [1:0] Op1None = 2'b00;
    localparam logic [1:0] Op1Base = 2'b01;
    localparam logic [1:0] Op1Reg  = 2'b11;

    // Operand-2 selects
    localparam logic [2:0] Op2Rs2   = 3'b000;
    localparam logic [2:0] Op2Iimm  = 3'b001;
    localparam logic [2:0] Op2Simm  = 3'b010;
    localparam logic [2:0] Op2Shamt = 3'b011;
    localparam logic [2:0] Op2Uimm  = 3'b100;
    localparam logic [2:0] Op2Bimm  = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StExec,
        StMem,
        StWb,
        StTrap
    } state_e;

    typedef enum logic [1:0] {
        ClsAlu,
        ClsLoad,
        ClsStore,
        ClsBranch
    } cls_e;

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: maps opcode/funct3/funct7[5] onto
// datapath selects, ALU op, legality and instruction class.
// Branch decode (BEQ/BNE) is present only when CU_BRANCH_EN is defined.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int unsigned ALU_W = 3
) (
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    output logic             muxrs1,
    output logic [1:0]       op1,
    output logic [2:0]       op2,
    output logic [ALU_W-1:0] alu,
    output logic             legal,
    output cls_e             cls
);

    logic [2:0] alu_code;

    // Field decode; an unsupported encoding yields legal=0 with all selects cleared
    always_comb begin
        muxrs1   = 1'b0;
        op1      = Op1Reg;
        op2      = Op2Rs2;
        alu_code = AluAdd;
        legal    = 1'b0;
        cls      = ClsAlu;
        case (opcode)
            OpcRtype: begin
                legal = 1'b1;
                case (funct3)
                    3'b000:  alu_code = funct7b5 ? AluSub : AluAdd;
                    3'b001:  alu_code = AluSll;
                    3'b010:  alu_code = AluSlt;
                    3'b100:  alu_code = AluXor;
                    3'b101:  alu_code = AluSrl;
                    3'b110:  alu_code = AluOr;
                    3'b111:  alu_code = AluAnd;
                    default: legal = 1'b0;
                endcase
                // bit 30 only selects SUB; elsewhere it marks SRA or a non-base op
                if (funct7b5 && (funct3 != 3'b000)) begin
                    legal = 1'b0;
                end
            end
            OpcItype: begin
                legal = 1'b1;
                op2   = Op2Iimm;
                case (funct3)
                    3'b000:  alu_code = AluAdd;
                    3'b010:  alu_code = AluSlt;
                    3'b100:  alu_code = AluXor;
                    3'b110:  alu_code = AluOr;
                    3'b111:  alu_code = AluAnd;
                    3'b001: begin
                        alu_code = AluSll;
                        op2      = Op2Shamt;
                        legal    = !funct7b5;
                    end
                    3'b101: begin
                        alu_code = AluSrl;
                        op2      = Op2Shamt;
                        legal    = !funct7b5;   // SRAI unsupported
                    end
                    default: legal = 1'b0;
                endcase
            end
            OpcLoad: begin
                legal = (funct3 == F3Word);
                op1   = Op1Base;
                op2   = Op2Iimm;
                cls   = ClsLoad;
            end
            OpcStore: begin
                legal = (funct3 == F3Word);
                op1   = Op1Base;
                op2   = Op2Simm;
                cls   = ClsStore;
            end
            OpcLui: begin
                legal  = 1'b1;
                muxrs1 = 1'b1;
                op2    = Op2Uimm;
            end
`ifdef CU_BRANCH_EN
            OpcBranch: begin
                legal    = (funct3[2:1] == 2'b00);
                alu_code = AluSub;
                op2      = Op2Bimm;
                cls      = ClsBranch;
            end
`endif
            default: ;
        endcase
        if (!legal) begin
            muxrs1   = 1'b0;
            op1      = Op1None;
            op2      = Op2Rs2;
            alu_code = AluAdd;
            cls      = ClsAlu;
        end
    end

    assign alu = ALU_W'(alu_code);

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: IDLE -> DECODE -> EXEC -> (MEM) -> (WB) -> IDLE,
// with TRAP for illegal encodings and memory timeouts.
// Optional macro CU_BRANCH_EN enables BEQ/BNE resolved in EXEC.
module mc_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned ALU_W       = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [6:0]       Opcode,
    input  logic [2:0]       Funct3,
    input  logic             Funct7b5,
    input  logic             Zero,
    input  logic             mem_done,
    output logic             Muxrs1,
    output logic [1:0]       Op1,
    output logic [2:0]       Op2,
    output logic [ALU_W-1:0] ALU,
    output logic             WriteEnable,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             Illegal
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [6:0]       opcode_q;
    logic [2:0]       funct3_q;
    logic             funct7b5_q;

    logic             dec_muxrs1;
    logic [1:0]       dec_op1;
    logic [2:0]       dec_op2;
    logic [ALU_W-1:0] dec_alu;
    logic             dec_legal;
    cls_e             dec_cls;
    logic             sel_active;

    cu_decoder #(
        .ALU_W (ALU_W)
    ) u_decoder (
        .opcode   (opcode_q),
        .funct3   (funct3_q),
        .funct7b5 (funct7b5_q),
        .muxrs1   (dec_muxrs1),
        .op1      (dec_op1),
        .op2      (dec_op2),
        .alu      (dec_alu),
        .legal    (dec_legal),
        .cls      (dec_cls)
    );

    // Datapath selects follow the latched instruction from DECODE until it retires
    assign sel_active = state_q inside {StDecode, StExec, StMem, StWb};
    assign Muxrs1     = sel_active & dec_muxrs1;
    assign Op1        = sel_active ? dec_op1 : Op1None;
    assign Op2        = sel_active ? dec_op2 : Op2Rs2;
    assign ALU        = sel_active ? dec_alu : '0;

`ifdef CU_BRANCH_EN
    // Branch outcome depends on the Zero flag of the EXEC-cycle subtraction
    assign PCSrc = (state_q == StExec) && (dec_cls == ClsBranch) && (Zero ^ funct3_q[0]);
`else
    logic unused_zero;
    assign unused_zero = Zero;
    assign PCSrc       = 1'b0;
`endif

    // Sequencer: next state, memory wait counter and registered control strobes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7b5_q  <= 1'b0;
            instr_ready <= 1'b1;
            WriteEnable <= 1'b0;
            MemWrite    <= 1'b0;
            MemRead     <= 1'b0;
            PCWrite     <= 1'b0;
            Illegal     <= 1'b0;
        end else begin
            WriteEnable <= 1'b0;
            PCWrite     <= 1'b0;
            Illegal     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (instr_valid && instr_ready) begin
                        opcode_q    <= Opcode;
                        funct3_q    <= Funct3;
                        funct7b5_q  <= Funct7b5;
                        instr_ready <= 1'b0;
                        state_q     <= StDecode;
                    end
                end
                StDecode: begin
                    if (!dec_legal) begin
                        Illegal <= 1'b1;
                        state_q <= StTrap;
                    end else begin
                        // branches update the PC during EXEC itself
                        PCWrite <= (dec_cls == ClsBranch);
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    case (dec_cls)
                        ClsLoad: begin
                            MemRead <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= StMem;
                        end
                        ClsStore: begin
                            MemWrite <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= StMem;
                        end
                        ClsBranch: begin
                            instr_ready <= 1'b1;
                            state_q     <= StIdle;
                        end
                        default: begin
                            WriteEnable <= 1'b1;
                            PCWrite     <= 1'b1;
                            state_q     <= StWb;
                        end
                    endcase
                end
                StMem: begin
                    if (mem_done) begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        PCWrite  <= 1'b1;
                        if (dec_cls == ClsLoad) begin
                            WriteEnable <= 1'b1;
                            state_q     <= StWb;
                        end else begin
                            instr_ready <= 1'b1;
                            state_q     <= StIdle;
                        end
                    end else if (cnt_q == CntW'(MEM_TIMEOUT - 1)) begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        Illegal  <= 1'b1;
                        state_q  <= StTrap;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWb, StTrap: begin
                    instr_ready <= 1'b1;
                    state_q     <= StIdle;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter ALU_W, default 3, width of ALU op code (legal >= 3).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, maximum MEM-state wait cycles before trap.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; all state SHALL be on posedge clock.
REQ-004 Ports SHALL be:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- instr_valid  in  1  instruction fields valid
- instr_ready  out  1  controller accepts instruction
- Opcode  in  7  instruction[6:0]
- Funct3  in  3  instruction[14:12]
- Funct7b5  in  1  instruction[30]
- Zero  in  1  ALU zero flag, sampled in EXEC
- mem_done  in  1  data memory access complete
- Muxrs1  out  1  1 = rs1 forced to x0
- Op1  out  2  operand-1 select (11 reg, 01 base reg)
- Op2  out  3  operand-2 select (000 rs2, 001 I-imm, 010 S-imm, 011 shamt, 100 U-imm, 101 B-imm)
- ALU  out  ALU_W  ALU operation
- WriteEnable  out  1  register-file write strobe
- MemWrite  out  1  data memory write
- MemRead  out  1  data memory read
- PCWrite  out  1  PC update strobe
- PCSrc  out  1  1 = PC <- branch target
- Illegal  out  1  illegal/timeout trap pulse

Function
REQ-005 FSM states SHALL be IDLE, DECODE, EXEC, MEM, WB, TRAP.
REQ-006 instr_ready SHALL be 1 only in IDLE; handshake = instr_valid && instr_ready; on handshake Opcode/Funct3/Funct7b5 SHALL be registered and FSM SHALL go to DECODE.
REQ-007 DECODE SHALL last exactly one cycle and drive Muxrs1/Op1/Op2/ALU from registered fields; unsupported encoding SHALL go to TRAP, else EXEC.
REQ-008 ALU codes SHALL be: 0 ADD, 1 SRL, 2 OR, 3 AND, 4 SUB, 5 XOR, 6 SLT, 7 SLL, zero-extended to ALU_W.
REQ-009 Supported: R-type (0110011) ADD/SUB (Funct7b5 selects), SLL, SLT, XOR, SRL, OR, AND; I-type (0010011) ADDI, SLTI, XORI, ORI, ANDI, SLLI, SRLI; LW (0000011,f3=010); SW (0100011,f3=010); LUI (0110111, Muxrs1=1, ADD, Op2=100).
REQ-010 EXEC SHALL last one cycle; LW/SW -> MEM; ALU ops and LUI -> WB.
REQ-011 MEM SHALL hold MemRead (LW) or MemWrite (SW) high until the cycle mem_done=1; LW -> WB, SW -> IDLE with PCWrite pulse.
REQ-012 A wait counter SHALL clear on MEM entry and increment per MEM cycle without mem_done; reaching MEM_TIMEOUT SHALL go to TRAP with MemRead/MemWrite dropped.
REQ-013 WB SHALL assert WriteEnable and PCWrite for exactly one cycle, then IDLE.
REQ-014 TRAP SHALL assert Illegal for exactly one cycle, never assert WriteEnable/MemWrite/PCWrite, then IDLE.
REQ-015 Latency: ALU/LUI = 4 cycles handshake-to-IDLE; LW/SW = 4 + mem wait cycles (+1 WB for LW).
REQ-016 mem_done outside MEM and instr_valid outside IDLE SHALL be ignored.

Reset
REQ-017 Reset SHALL force IDLE, counter 0, all outputs 0 except instr_ready=1, immediately and regardless of state (including mid-MEM).

Configuration
REQ-018 With macro CU_BRANCH_EN defined, BEQ/BNE (1100011, f3 000/001) SHALL decode to SUB, Op2=101, EXEC sampling Zero, PCSrc=taken, PCWrite pulse in EXEC, then IDLE; without it opcode 1100011 SHALL go to TRAP and PCSrc SHALL be constant 0.

Structure
REQ-019 Shared package cu_pkg SHALL hold opcode constants, ALU code constants, Op1/Op2 select constants and the state enum.
REQ-020 Combinational decode SHALL be a sub-module cu_decoder (fields in; Muxrs1/Op1/Op2/ALU/legal/class out); FSM and counter stay in mc_control_unit.

Verification
REQ-021 ADD x (Opcode 0110011, f3 000, f7b5 0) -> ALU=0, Op1=11, Op2=000, WriteEnable pulse in cycle 4 only.
REQ-022 SRLI (0010011, f3 101) -> ALU=1, Op2=011; SUB (f7b5 1) -> ALU=4.
REQ-023 LW with mem_done after 3 cycles -> MemRead high 3 cycles, then WB WriteEnable pulse; SW same -> MemWrite high, no WriteEnable.
REQ-024 SW with mem_done never -> after 15 MEM cycles Illegal pulse, MemWrite low, back to IDLE.
REQ-025 Opcode 1111111 -> Illegal one cycle after DECODE, no writes; BEQ with Zero=1 -> PCSrc=1 with CU_BRANCH_EN, Illegal without.
REQ-026 reset asserted during MEM -> next edge-independent IDLE, MemWrite=0, instr_ready=1.
